output_register_mux: RTL

- Parametrised successor to the 8-bit bus output register: latches a DATA_WIDTH-bit value from the bus and converts it to BCD with a sequential shift-add-3 engine, one bit per cycle.
- Drives NUM_DIGITS multiplexed 7-segment digits from the single system clock through an internal scan prescaler; no second clock.
- Flags values that do not fit in NUM_DIGITS digits.
- Sits on the computer bus as the output device; input_en comes from the control unit.

---
 rtl/output_register_mux.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/output_register_mux.sv
// output_register_mux: bus output register with a sequential binary-to-BCD
// converter and a multiplexed 7-segment scanner. The conversion uses
// shift-add-3 at one bit per clk. Digits are scanned from the system clock
// through a prescaler.
// Optional feature macro: OUTPUT_REGISTER_LZ_BLANK_EN (leading-zero blanking).
module output_register_mux #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_DIGITS = 3,
    parameter int SCAN_DIV   = 1024
) (
    input  logic                  clk,
    input  logic                  clear,
    input  logic [DATA_WIDTH-1:0] bus,
    input  logic                  input_en,
    output logic [6:0]            display,
    output logic [NUM_DIGITS-1:0] display_en,
    output logic                  busy,
    output logic                  overflow
);

    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int CW    = $clog2(DATA_WIDTH);
    localparam int PW    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    localparam logic [CW-1:0]         BIT_LAST = CW'(DATA_WIDTH - 1);
    localparam logic [PW-1:0]         PRE_LAST = PW'(SCAN_DIV - 1);
    localparam logic [NUM_DIGITS-1:0] EN_RESET = ~NUM_DIGITS'(1);

    localparam logic [6:0] SEG_DASH  = 7'b0000001;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_stateNext;
    logic                    w_busy;

    logic [DATA_WIDTH-1:0]   r_data;
    logic [BCD_W-1:0]        r_bcd;
    logic                    r_ovfPending;
    logic [CW-1:0]           r_bitCnt;
    logic [BCD_W-1:0]        r_digits;
    logic                    r_overflow;

    logic [BCD_W-1:0]        w_bcdAdj;
    logic [BCD_W-1:0]        w_bcdNext;
    logic [DATA_WIDTH-1:0]   w_dataNext;
    logic                    w_shiftOut;

    logic [PW-1:0]           r_prescale;
    logic [NUM_DIGITS-1:0]   r_digitEn;
    logic [NUM_DIGITS-1:0]   w_enRot;

    logic [NUM_DIGITS-1:0]   w_blank;
    logic [3:0]              w_selNibble;
    logic                    w_selBlank;

    // Seven-segment pattern for one BCD nibble; non-decimal codes go blank
    function automatic logic [6:0] segDecode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'd0:    seg = 7'b1111110;
            4'd1:    seg = 7'b0110000;
            4'd2:    seg = 7'b1101101;
            4'd3:    seg = 7'b1111001;
            4'd4:    seg = 7'b0110011;
            4'd5:    seg = 7'b1011011;
            4'd6:    seg = 7'b1011111;
            4'd7:    seg = 7'b1110000;
            4'd8:    seg = 7'b1111111;
            4'd9:    seg = 7'b1111011;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

    // Conversion state register
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next state and busy; a capture restarts the conversion from any state
    always_comb begin
        w_stateNext = r_state;
        w_busy      = 1'b0;
        case (r_state)
            IDLE: begin
                w_stateNext = IDLE;
            end
            SHIFT: begin
                w_busy = 1'b1;
                if (r_bitCnt == BIT_LAST) begin
                    w_stateNext = COMMIT;
                end
            end
            COMMIT: begin
                w_busy      = 1'b1;
                w_stateNext = IDLE;
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
        if (input_en) begin
            w_stateNext = SHIFT;
        end
    end

    assign busy = w_busy;

    // Add-3 correction on each nibble, then one-bit left shift of {bcd, data}
    always_comb begin
        w_bcdAdj = r_bcd;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_bcd[4*i +: 4] > 4'd4) begin
                w_bcdAdj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
            end
        end
        w_shiftOut = w_bcdAdj[BCD_W-1];
        w_bcdNext  = {w_bcdAdj[BCD_W-2:0], r_data[DATA_WIDTH-1]};
        w_dataNext = {r_data[DATA_WIDTH-2:0], 1'b0};
    end

    // Working registers and committed digits; digits change only in COMMIT
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            r_data       <= '0;
            r_bcd        <= '0;
            r_ovfPending <= 1'b0;
            r_bitCnt     <= '0;
            r_digits     <= '0;
            r_overflow   <= 1'b0;
        end else if (input_en) begin
            r_data       <= bus;
            r_bcd        <= '0;
            r_ovfPending <= 1'b0;
            r_bitCnt     <= '0;
        end else begin
            case (r_state)
                SHIFT: begin
                    r_data       <= w_dataNext;
                    r_bcd        <= w_bcdNext;
                    r_ovfPending <= r_ovfPending | w_shiftOut;
                    r_bitCnt     <= r_bitCnt + 1'b1;
                end
                COMMIT: begin
                    r_digits     <= r_bcd;
                    r_overflow   <= r_ovfPending;
                    r_data       <= '0;
                    r_bcd        <= '0;
                    r_ovfPending <= 1'b0;
                    r_bitCnt     <= '0;
                end
                default: begin
                end
            endcase
        end
    end

    // Rotation of the active-low digit enable toward the next higher digit
    generate
        if (NUM_DIGITS == 1) begin : g_singleDigit
            assign w_enRot = 1'b0;
        end else begin : g_multiDigit
            assign w_enRot = {r_digitEn[NUM_DIGITS-2:0], r_digitEn[NUM_DIGITS-1]};
        end
    endgenerate

    // Scan prescaler; it runs regardless of conversion activity
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            r_prescale <= '0;
            r_digitEn  <= EN_RESET;
        end else if (r_prescale == PRE_LAST) begin
            r_prescale <= '0;
            r_digitEn  <= w_enRot;
        end else begin
            r_prescale <= r_prescale + 1'b1;
        end
    end

    assign display_en = r_digitEn;
    assign overflow   = r_overflow;

`ifdef OUTPUT_REGISTER_LZ_BLANK_EN
    logic w_upperZero;

    // Blank a digit when it and every digit above it are zero; digit0 always shows
    always_comb begin
        w_blank     = '0;
        w_upperZero = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            w_upperZero = w_upperZero & (r_digits[4*i +: 4] == 4'd0);
            w_blank[i]  = w_upperZero;
        end
    end
`else
    assign w_blank = '0;
`endif

    // Pick the committed nibble of the digit whose enable is low
    always_comb begin
        w_selNibble = 4'd0;
        w_selBlank  = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!r_digitEn[i]) begin
                w_selNibble = r_digits[4*i +: 4];
                w_selBlank  = w_blank[i];
            end
        end
    end

    // Segment output; overflow dashes override blanking and digit values
    always_comb begin
        if (r_overflow) begin
            display = SEG_DASH;
        end else if (w_selBlank) begin
            display = SEG_BLANK;
        end else begin
            display = segDecode(w_selNibble);
        end
    end

endmodule
